pwm_step_sequencer: RTL and testbench
=====================================

// Module: pwm_step_sequencer
// PURPOSE
// - Programs and sequences one PWM channel (16-bit cnt/cmp/top core with d/sel write bus) through a table of duty steps.
// - Each entry holds a compare value and a duration in whole PWM periods; after start the block writes top, zeroes cnt,
//   then loads each cmp in turn, counting period wraps. Sits between host control logic and the PWM core's write port.
// PARAMETERS
// - W      16  data width of PWM cnt/cmp/top and of pwm_d
// - DEPTH   8  table entries (power of 2, >=2); AW = $clog2(DEPTH)
// - DUR_W   8  width of per-entry duration field
// PORTS
// - clk       in   1      clock, all state on posedge
// - rst       in   1      asynchronous, active-high reset
// - start     in   1      1-cycle pulse: begin sequence (ignored while busy)
// - stop      in   1      abort; priority over start
// - n_steps   in   AW+1   entries used, 1..DEPTH; 0 -> start ignored; >DEPTH clamps to DEPTH; sampled on accepted start
// - cfg_top   in   W      period value written to PWM top; sampled on accepted start
// - tbl_we    in   1      table write strobe
// - tbl_addr  in   AW     table write index
// - tbl_cmp   in   W      compare value for entry
// - tbl_dur   in   DUR_W  periods for entry; 0 treated as 1
// - pwm_cnt   in   W      PWM core counter
// - pwm_top   in   W      PWM core top register
// - pwm_d     out  W      PWM write data
// - pwm_sel   out  2      PWM write select: 0 none, 1 cmp, 2 top, 3 cnt
// - busy      out  1      high in any state except IDLE
// - done      out  1      1-cycle pulse on sequence completion
// - step_idx  out  AW     current table index
// BEHAVIOUR
// - Reset: state IDLE, pwm_sel=0, pwm_d=0, busy=0, done=0, step_idx=0, remaining=0, all table entries cmp=0/dur=0.
// - pwm_sel/pwm_d are Moore decodes of state (sel=0,d=0 in IDLE/WAIT); PWM latches them at the end of that cycle.
// - States: IDLE, TOP, CNT, CMP, WAIT, OFF.
//   IDLE: start & n_steps!=0 & !stop -> TOP; latch n_steps (clamped), cfg_top; step_idx=0.
//   TOP : sel=2, d=cfg_top -> CNT.   CNT: sel=3, d=0 -> CMP (PWM cnt=0 during CMP).
//   CMP : sel=1, d=tbl_cmp[step_idx]; remaining loaded = max(tbl_dur[step_idx],1) on entry.
//   WAIT: no write; waits for wraps.
//   OFF : sel=1, d=0 (forces PWM output low) -> IDLE.
// - Wrap cycle: any CMP or WAIT cycle with pwm_cnt >= pwm_top; decrements remaining.
//   Final wrap (remaining==1): if step_idx<n_steps-1 -> step_idx+1, CMP; else last-step end (see CONFIGURATION).
//   Otherwise CMP -> WAIT, WAIT holds. top=0 makes every cycle a wrap.
// - New cmp is written during the cnt==0 cycle; it takes effect from cnt==1 of that period.
// - stop in any non-IDLE state -> OFF next cycle; done not pulsed; step_idx kept until next start. stop in IDLE: no effect.
// - start while busy ignored. tbl_we always accepted; an entry is read only at CMP, so edits apply from its next load.
// - Async rst mid-sequence returns to reset values immediately; PWM core not written (its state untouched).
// CONFIGURATION
// - PWM_SEQ_LOOP_EN defined: on last-step final wrap, step_idx=0 -> CMP, done pulses that cycle, busy stays 1;
//   only stop or rst end the sequence.
// - Undefined: on last-step final wrap -> IDLE, done=1 for the following cycle (first IDLE cycle), busy=0;
//   last cmp stays in the PWM.
// TESTING
// - Timing: top=3, entries {cmp=1,dur=2},{cmp=3,dur=1}, n_steps=2, start@c0 -> sel=2 c1, sel=3 c2, sel=1/d=1 c3,
//   sel=1/d=3 c11, done=1 c15, busy=0 c15.
// - stop at c8 of timing run -> sel=1,d=0 at c9, IDLE c10, done never 1, PWM out low.
// - n_steps=0 start -> stays IDLE, pwm_sel=0; n_steps=12 with DEPTH=8 -> eight CMP writes then done.
// - dur=0 entry with top=3 -> held exactly one period (4 cycles CMP to next CMP); top=0, dur=3 -> 3 cycles per step.
// - rst asserted mid-WAIT -> same cycle busy=0, pwm_sel=0, step_idx=0; next start restarts from TOP.
// - PWM_SEQ_LOOP_EN, timing table -> done pulses c11+... every 12 cycles (c14, c26), sel=1/d=1 at c15; stop exits.

Source files
------------

// File: rtl/pwm_step_sequencer.sv
// pwm_step_sequencer: programs one PWM channel (top, cnt, cmp via pwm_d/pwm_sel) and
// steps it through a table of (compare value, duration in periods) entries.
// Build macro PWM_SEQ_LOOP_EN: when defined, the table repeats until stop/rst and done
// pulses on each pass; when undefined, the sequence ends in IDLE after the last entry.
//
// state | meaning
// IDLE  | waiting for an accepted start
// TOP   | writing the latched period value to PWM top
// CNT   | zeroing the PWM counter
// CMP   | writing the current entry's compare value (PWM cnt==0 in this cycle)
// WAIT  | counting period wraps for the current entry
// OFF   | forcing PWM compare to 0 after an abort
module pwm_step_sequencer #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int DUR_W = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [AW:0]      n_steps,
  input  logic [W-1:0]     cfg_top,
  input  logic             tbl_we,
  input  logic [AW-1:0]    tbl_addr,
  input  logic [W-1:0]     tbl_cmp,
  input  logic [DUR_W-1:0] tbl_dur,
  input  logic [W-1:0]     pwm_cnt,
  input  logic [W-1:0]     pwm_top,
  output logic [W-1:0]     pwm_d,
  output logic [1:0]       pwm_sel,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    step_idx
);

`ifdef PWM_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_TOP, S_CNT, S_CMP, S_WAIT, S_OFF} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    step_idx_q, step_idx_d;
  logic [AW-1:0]    last_idx_q, last_idx_d;
  logic [W-1:0]     top_q, top_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [W-1:0]     tbl_cmp_q [DEPTH];
  logic [W-1:0]     tbl_cmp_d [DEPTH];
  logic [DUR_W-1:0] tbl_dur_q [DEPTH];
  logic [DUR_W-1:0] tbl_dur_d [DEPTH];

  logic [AW:0]      ns_clamp;
  logic [DUR_W-1:0] dur_cur, rem_cur;
  logic             start_ok, in_step, wrap, final_wrap, last_step, seq_end;

  // Shared decode: the duration is read from the table only while in CMP, so a table
  // edit takes effect the next time that entry is loaded.
  always_comb begin
    ns_clamp   = (n_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : n_steps;
    start_ok   = (state_q == S_IDLE) && start && !stop && (n_steps != '0);
    dur_cur    = tbl_dur_q[step_idx_q];
    rem_cur    = (state_q == S_CMP) ? ((dur_cur == '0) ? DUR_W'(1) : dur_cur) : rem_q;
    in_step    = (state_q == S_CMP) || (state_q == S_WAIT);
    wrap       = in_step && (pwm_cnt >= pwm_top);
    final_wrap = wrap && (rem_cur == DUR_W'(1));
    last_step  = (step_idx_q == last_idx_q);
    seq_end    = final_wrap && last_step && !stop;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; stop overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_TOP;
      S_TOP:  state_d = S_CNT;
      S_CNT:  state_d = S_CMP;
      S_CMP, S_WAIT: begin
        if (final_wrap) state_d = (last_step && !LOOP_EN) ? S_IDLE : S_CMP;
        else            state_d = S_WAIT;
      end
      S_OFF:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (stop && (state_q != S_IDLE)) state_d = S_OFF;
  end

  // Sequencing datapath: step index, latched config and the wrap down-counter.
  always_comb begin
    step_idx_d = step_idx_q;
    last_idx_d = last_idx_q;
    top_d      = top_q;
    rem_d      = rem_q;
    if (start_ok) begin
      step_idx_d = '0;
      last_idx_d = AW'(ns_clamp - (AW+1)'(1));
      top_d      = cfg_top;
    end
    if (in_step && !stop) begin
      rem_d = wrap ? (rem_cur - DUR_W'(1)) : rem_cur;
      if (final_wrap) begin
        if (!last_step)   step_idx_d = step_idx_q + 1'b1;
        else if (LOOP_EN) step_idx_d = '0;
      end
    end
  end

  // Step table write port; always accepted regardless of state.
  always_comb begin
    tbl_cmp_d = tbl_cmp_q;
    tbl_dur_d = tbl_dur_q;
    if (tbl_we) begin
      tbl_cmp_d[tbl_addr] = tbl_cmp;
      tbl_dur_d[tbl_addr] = tbl_dur;
    end
  end

  // Datapath and table registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_idx_q <= '0;
      last_idx_q <= '0;
      top_q      <= '0;
      rem_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_cmp_q[i] <= '0;
        tbl_dur_q[i] <= '0;
      end
    end else begin
      step_idx_q <= step_idx_d;
      last_idx_q <= last_idx_d;
      top_q      <= top_d;
      rem_q      <= rem_d;
      tbl_cmp_q  <= tbl_cmp_d;
      tbl_dur_q  <= tbl_dur_d;
    end
  end

`ifdef PWM_SEQ_LOOP_EN
  // Looping: done marks the wrap that restarts the table, so it is combinational.
  always_comb done = seq_end;
`else
  logic done_q, done_d;

  // One-shot: done is the first IDLE cycle after the last entry's final wrap.
  always_comb done_d = seq_end;

  // Completion flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= done_d;
  end

  always_comb done = done_q;
`endif

  // Moore output decode of the PWM write port and status.
  always_comb begin
    pwm_sel = 2'd0;
    pwm_d   = '0;
    case (state_q)
      S_TOP: begin pwm_sel = 2'd2; pwm_d = top_q; end
      S_CNT: begin pwm_sel = 2'd3; pwm_d = '0; end
      S_CMP: begin pwm_sel = 2'd1; pwm_d = tbl_cmp_q[step_idx_q]; end
      S_OFF: begin pwm_sel = 2'd1; pwm_d = '0; end
      default: ;
    endcase
    busy     = (state_q != S_IDLE);
    step_idx = step_idx_q;
  end

endmodule

// File: tb/tb_pwm_step_sequencer.sv
`timescale 1ns/1ps
module tb_pwm_step_sequencer;
  localparam int W = 16, DEPTH = 8, DUR_W = 8, AW = 3;

  logic clk = 0, rst = 0, start = 0, stop = 0, tbl_we = 0;
  logic [AW:0]      n_steps = '0;
  logic [W-1:0]     cfg_top = '0, tbl_cmp = '0;
  logic [AW-1:0]    tbl_addr = '0;
  logic [DUR_W-1:0] tbl_dur = '0;
  logic [W-1:0]     pwm_cnt, pwm_top, pwm_d;
  logic [1:0]       pwm_sel;
  logic             busy, done;
  logic [AW-1:0]    step_idx;

  // Behavioural PWM core receiving the write port.
  logic [W-1:0] m_cnt = '0, m_top = 16'hFFFF, m_cmp = '0;
  int cyc = 0, base = 0, n_tests = 0, n_fail = 0;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [W-1:0] d;
    logic       done;
    logic       busy;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;

  pwm_step_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .n_steps(n_steps),
    .cfg_top(cfg_top), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_cmp(tbl_cmp),
    .tbl_dur(tbl_dur), .pwm_cnt(pwm_cnt), .pwm_top(pwm_top), .pwm_d(pwm_d),
    .pwm_sel(pwm_sel), .busy(busy), .done(done), .step_idx(step_idx)
  );

  assign pwm_cnt = m_cnt;
  assign pwm_top = m_top;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pwm_sel == 2'd3) m_cnt <= pwm_d;
    else                 m_cnt <= (m_cnt >= m_top) ? '0 : m_cnt + 1'b1;
    if (pwm_sel == 2'd2) m_top <= pwm_d;
    if (pwm_sel == 2'd1) m_cmp <= pwm_d;
  end

  // Monitor: every PWM write or done pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst && (pwm_sel != 2'd0 || done)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: c%0d sel=%0d d=%0d done=%0b busy=%0b, expected no event",
                 cyc - base, pwm_sel, pwm_d, done, busy);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc - base || mon_e.sel !== pwm_sel || mon_e.d !== pwm_d ||
            mon_e.done !== done || mon_e.busy !== busy) begin
          n_fail++;
          $display("FAIL event: got c%0d sel=%0d d=%0d done=%0b busy=%0b, expected c%0d sel=%0d d=%0d done=%0b busy=%0b",
                   cyc - base, pwm_sel, pwm_d, done, busy,
                   mon_e.cyc, mon_e.sel, mon_e.d, mon_e.done, mon_e.busy);
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(int c, int s, int d, logic dn, logic b);
    ev_t e;
    e.cyc = c; e.sel = 2'(s); e.d = W'(d); e.done = dn; e.busy = b;
    exp_q.push_back(e);
  endtask

  task automatic wr_tbl(int idx, int c, int dur);
    @(negedge clk); #1;
    tbl_we = 1; tbl_addr = AW'(idx); tbl_cmp = W'(c); tbl_dur = DUR_W'(dur);
    @(negedge clk); #1;
    tbl_we = 0;
  endtask

  task automatic do_start(int ns, int top, logic stp);
    @(negedge clk); #1;
    start = 1; stop = stp; n_steps = (AW+1)'(ns); cfg_top = W'(top); base = cyc;
    @(negedge clk); #1;
    start = 0; stop = 0;
  endtask

  task automatic wait_rel(int r);
    while (cyc - base < r) @(negedge clk);
    #1;
  endtask

  task automatic drain(string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 200) begin @(negedge clk); i++; end
    repeat (6) @(negedge clk);
    #1;
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic load_timing_tbl();
    wr_tbl(0, 1, 2);
    wr_tbl(1, 3, 1);
  endtask

  task automatic push_timing_head();
    push(1, 2, 3, 0, 1);
    push(2, 3, 0, 0, 1);
    push(3, 1, 1, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sel", pwm_sel, 0);
    chk("rst_d", pwm_d, 0);
    chk("rst_idx", step_idx, 0);
    rst = 0;

`ifdef PWM_SEQ_LOOP_EN
    load_timing_tbl();
    push_timing_head();
    push(11, 1, 3, 0, 1);
    push(14, 0, 0, 1, 1);
    push(15, 1, 1, 0, 1);
    push(23, 1, 3, 0, 1);
    push(26, 0, 0, 1, 1);
    push(27, 1, 1, 0, 1);
    push(29, 1, 0, 0, 1);
    do_start(2, 3, 0);
    wait_rel(28); stop = 1;
    wait_rel(29); stop = 0;
    wait_rel(30);
    chk("loop_stop_idle", busy, 0);
    drain("loop");
`else
    // Reference timing run; a second start while busy must be ignored.
    load_timing_tbl();
    push_timing_head();
    push(11, 1, 3, 0, 1);
    push(15, 0, 0, 1, 0);
    do_start(2, 3, 0);
    wait_rel(5); start = 1; n_steps = 1; cfg_top = 9;
    wait_rel(6); start = 0;
    drain("timing");

    // Abort during the first entry.
    push_timing_head();
    push(9, 1, 0, 0, 1);
    do_start(2, 3, 0);
    wait_rel(8); stop = 1;
    wait_rel(9); stop = 0;
    wait_rel(10);
    chk("stop8_busy", busy, 0);
    chk("stop8_idx", step_idx, 0);
    chk("stop8_pwm_cmp", m_cmp, 0);
    drain("stop8");

    // Abort during the second entry keeps step_idx.
    push_timing_head();
    push(11, 1, 3, 0, 1);
    push(13, 1, 0, 0, 1);
    do_start(2, 3, 0);
    wait_rel(12); stop = 1;
    wait_rel(13); stop = 0;
    wait_rel(14);
    chk("stop12_busy", busy, 0);
    chk("stop12_idx", step_idx, 1);
    drain("stop12");

    // n_steps=0 and start together with stop are both ignored.
    do_start(0, 3, 0);
    wait_rel(4);
    chk("nsteps0_busy", busy, 0);
    chk("nsteps0_sel", pwm_sel, 0);
    do_start(2, 3, 1);
    wait_rel(4);
    chk("start_stop_busy", busy, 0);
    drain("ignored");

    // n_steps=12 clamps to 8; live edits apply only to entries not yet loaded.
    for (int i = 0; i < DEPTH; i++) wr_tbl(i, 10 + i, 1);
    push(1, 2, 3, 0, 1);
    push(2, 3, 0, 0, 1);
    for (int k = 0; k < DEPTH; k++) push(3 + 4 * k, 1, (k == 5) ? 99 : 10 + k, 0, 1);
    push(35, 0, 0, 1, 0);
    do_start(12, 3, 0);
    wait_rel(5); tbl_we = 1; tbl_addr = 3'd5; tbl_cmp = 16'd99; tbl_dur = 8'd1;
    wait_rel(6); tbl_addr = 3'd0; tbl_cmp = 16'd77;
    wait_rel(7); tbl_we = 0;
    drain("clamp");

    // dur=0 entries last exactly one period.
    wr_tbl(0, 5, 0);
    wr_tbl(1, 6, 0);
    push(1, 2, 3, 0, 1);
    push(2, 3, 0, 0, 1);
    push(3, 1, 5, 0, 1);
    push(7, 1, 6, 0, 1);
    push(11, 0, 0, 1, 0);
    do_start(2, 3, 0);
    drain("dur0");

    // top=0: every cycle wraps, dur=3 gives three cycles per entry.
    wr_tbl(0, 7, 3);
    wr_tbl(1, 8, 3);
    push(1, 2, 0, 0, 1);
    push(2, 3, 0, 0, 1);
    push(3, 1, 7, 0, 1);
    push(6, 1, 8, 0, 1);
    push(9, 0, 0, 1, 0);
    do_start(2, 0, 0);
    drain("top0");

    // Async reset in WAIT of the second entry, then a clean restart.
    load_timing_tbl();
    push_timing_head();
    push(11, 1, 3, 0, 1);
    do_start(2, 3, 0);
    wait_rel(13);
    chk("pre_rst_idx", step_idx, 1);
    rst = 1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sel", pwm_sel, 0);
    chk("midrst_idx", step_idx, 0);
    chk("midrst_done", done, 0);
    @(negedge clk); #1;
    rst = 0;
    chk("midrst_pending", exp_q.size(), 0);
    load_timing_tbl();
    push_timing_head();
    push(11, 1, 3, 0, 1);
    push(15, 0, 0, 1, 0);
    do_start(2, 3, 0);
    drain("restart");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
